writeback_queue: RTL and testbench
==================================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entry count (power of 2, minimum 2).
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, meaning reset; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit, meaning the producer offers a result.
REQ-005 SHALL have port in_ready, output, 1 bit, meaning the queue accepts the result this cycle.
REQ-006 SHALL have port in_rd, input, 5 bits, meaning the destination register index.
REQ-007 SHALL have port in_data, input, 32 bits, meaning the result value.
REQ-008 SHALL have port wb_stall, input, 1 bit, meaning the register file write port is unavailable this cycle.
REQ-009 SHALL have ports wb_we, wb_rd and wb_wd, outputs, 1/5/32 bits, meaning the write enable, index and data driven to the register file.
REQ-010 SHALL have ports rs1 and rs2, inputs, 5 bits each, meaning the read indices currently presented to the register file.
REQ-011 SHALL have ports rs1_fwd and rs2_fwd, outputs, 1 bit each, meaning a queued entry is pending for that index.
REQ-012 SHALL have ports rs1_fwd_data and rs2_fwd_data, outputs, 32 bits each, meaning the forwarded value.
REQ-013 SHALL have port count, output, clog2(DEPTH)+1 bits, meaning the current occupancy.

Function
REQ-014 SHALL implement a circular FIFO of {rd, data} with read and write pointers that wrap modulo DEPTH.
REQ-015 SHALL define push = in_valid && in_ready && in_rd != 0.
REQ-016 SHALL handshake an in_valid with in_rd == 0 (accepted if in_ready) but SHALL NOT store it; count is unchanged.
REQ-017 SHALL define pop = (count != 0) && !wb_stall.
REQ-018 SHALL drive in_ready = (count < DEPTH) || pop, combinationally; when full and popping, it accepts.
REQ-019 SHALL drive wb_we = pop, combinationally.
REQ-020 SHALL drive wb_rd and wb_wd as the head entry; both are 0 when count == 0.
REQ-021 SHALL update count on a clock edge as follows: push and pop together leave it unchanged; push alone increments it; pop alone decrements it.
REQ-022 SHALL give a minimum latency of 1 cycle: a result pushed at edge N is presented on wb_* in cycle N+1.
REQ-023 SHALL never push and pop the same entry in one cycle (no combinational input-to-wb path).
REQ-024 SHALL preserve write order; duplicate rd values SHALL all be retained and written in order.
REQ-025 SHALL assert rsX_fwd when rsX != 0 and any valid entry has rd == rsX, including the head while it is being popped.
REQ-026 SHALL make rsX_fwd_data the data of the youngest matching entry; it is 0 when there is no match.
REQ-027 SHALL compute forwarding only over stored entries; the in_* inputs of the current cycle SHALL NOT be forwarded.
REQ-028 SHALL keep forwarding consistent after a pop: the entry leaves the queue at the same edge the register file captures it.

Reset
REQ-029 SHALL, while rst is high at a clock edge, clear both pointers and count; entry contents are don't-care.
REQ-030 SHALL hold in_ready=1, wb_we=0, wb_rd=0, wb_wd=0, rsX_fwd=0, rsX_fwd_data=0 and count=0 in the cycle following reset.
REQ-031 SHALL treat reset asserted mid-operation as discarding all queued entries: no further wb_we for them, and a push in the reset cycle is dropped.
REQ-032 SHALL give rst priority over push and pop in the same cycle.

Verification
REQ-033 SHALL be verified as follows: push rd=5, data=0xDEADBEEF, with wb_stall=0 -> next cycle wb_we=1, wb_rd=5, wb_wd=0xDEADBEEF, count 1->0.
REQ-034 SHALL be verified as follows: wb_stall=1, push rd=1..4 -> count=4, in_ready=0; then wb_stall=0 with a new push -> pop and push in the same cycle, count stays 4, writes emerge as rd 1,2,3,4 in order.
REQ-035 SHALL be verified as follows: push rd=7/0x11, then rd=7/0x22, with stall held, rs1=7 -> rs1_fwd=1, rs1_fwd_data=0x22; rs2=0 -> rs2_fwd=0.
REQ-036 SHALL be verified as follows: push rd=0, data=0xFFFF -> in_ready=1, count stays 0, and wb_we never asserts.
REQ-037 SHALL be verified as follows: fill 3 entries, assert rst for one cycle together with in_valid -> count=0, wb_we=0 thereafter, rs1_fwd=0.
REQ-038 SHALL be verified as follows: run 2*DEPTH+1 push/pop cycles at full rate -> pointers wrap, data integrity holds, and count never exceeds DEPTH.

Source files
------------

// File: rtl/writeback_queue.sv
// Register-file writeback queue: a small circular FIFO of {rd, data} results.
// Stored entries are forwarded to the rs1/rs2 read ports until they are written back.
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_rd,
    input  logic [31:0]              in_data,
    input  logic                     wb_stall,
    output logic                     wb_we,
    output logic [4:0]               wb_rd,
    output logic [31:0]              wb_wd,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    output logic                     rs1_fwd,
    output logic                     rs2_fwd,
    output logic [31:0]              rs1_fwd_data,
    output logic [31:0]              rs2_fwd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [4:0]    r_rd   [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic w_pop;
    logic w_push;
    logic w_empty;

    // Reset wins over a pending writeback so discarded entries never reach the register file.
    assign w_empty  = (r_count == '0);
    assign w_pop    = !w_empty && !wb_stall && !rst;
    assign in_ready = (r_count < (AW+1)'(DEPTH)) || w_pop;
    assign w_push   = in_valid && in_ready && (in_rd != 5'd0);

    assign wb_we = w_pop;
    assign wb_rd = w_empty ? 5'd0  : r_rd[r_rptr];
    assign wb_wd = w_empty ? 32'd0 : r_data[r_rptr];
    assign count = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_wptr]   <= in_rd;
            r_data[r_wptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Scan oldest to youngest so the last match seen is the youngest entry.
    always_comb begin
        logic [AW-1:0] w_idx;
        rs1_fwd      = 1'b0;
        rs2_fwd      = 1'b0;
        rs1_fwd_data = 32'd0;
        rs2_fwd_data = 32'd0;
        w_idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rptr + AW'(i);
            if ((AW+1)'(i) < r_count) begin
                if (rs1 != 5'd0 && r_rd[w_idx] == rs1) begin
                    rs1_fwd      = 1'b1;
                    rs1_fwd_data = r_data[w_idx];
                end
                if (rs2 != 5'd0 && r_rd[w_idx] == rs2) begin
                    rs2_fwd      = 1'b1;
                    rs2_fwd_data = r_data[w_idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: a queue-based model checked every cycle, plus
// hand-computed expectations for the directed scenarios.
module tb_writeback_queue;
    localparam int DEPTH = 4;
    localparam int W     = 37;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_data = '0;
    logic        wb_stall = 1'b0;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        rs1_fwd, rs2_fwd;
    logic [31:0] rs1_fwd_data, rs2_fwd_data;
    logic [$clog2(DEPTH):0] count;

    int tests  = 0;
    int failed = 0;

    logic [W-1:0] exp_q[$];

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
        .wb_stall(wb_stall), .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
        .rs1(rs1), .rs2(rs2),
        .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
        .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
        .count(count)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // model helpers
    function automatic logic model_pop();
        return (exp_q.size() != 0) && !wb_stall;
    endfunction

    function automatic logic model_ready();
        return (exp_q.size() < DEPTH) || model_pop();
    endfunction

    task automatic model_fwd(input logic [4:0] rs, output logic hit, output logic [31:0] val);
        hit = 1'b0;
        val = 32'd0;
        if (rs != 5'd0) begin
            foreach (exp_q[k]) begin
                if (exp_q[k][36:32] == rs) begin
                    hit = 1'b1;
                    val = exp_q[k][31:0];
                end
            end
        end
    endtask

    // model update on each edge
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            logic p, r;
            p = model_pop();
            r = model_ready();
            if (p) void'(exp_q.pop_front());
            if (in_valid && r && in_rd != 5'd0) exp_q.push_back({in_rd, in_data});
        end
    end

    // compare process: every non-reset cycle
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            logic h1, h2;
            logic [31:0] v1, v2;
            model_fwd(rs1, h1, v1);
            model_fwd(rs2, h2, v2);
            chk("in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
            chk("wb_we", {31'd0, wb_we}, {31'd0, model_pop()});
            chk("wb_rd", {27'd0, wb_rd}, exp_q.size() != 0 ? {27'd0, exp_q[0][36:32]} : 32'd0);
            chk("wb_wd", wb_wd, exp_q.size() != 0 ? exp_q[0][31:0] : 32'd0);
            chk("count", 32'(count), 32'(exp_q.size()));
            chk("count_le_depth", {31'd0, (32'(count) <= DEPTH)}, 32'd1);
            chk("rs1_fwd", {31'd0, rs1_fwd}, {31'd0, h1});
            chk("rs1_fwd_data", rs1_fwd_data, v1);
            chk("rs2_fwd", {31'd0, rs2_fwd}, {31'd0, h2});
            chk("rs2_fwd_data", rs2_fwd_data, v2);
        end
    end

    // driver: apply inputs for one cycle, return after outputs settle
    task automatic step(input logic r, input logic v, input logic [4:0] rd, input logic [31:0] d,
                        input logic st, input logic [4:0] a, input logic [4:0] b);
        @(negedge clk);
        rst = r; in_valid = v; in_rd = rd; in_data = d; wb_stall = st; rs1 = a; rs2 = b;
        #3;
    endtask

    task automatic idle(input logic st);
        step(1'b0, 1'b0, 5'd0, 32'd0, st, 5'd0, 5'd0);
    endtask

    initial begin
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3, 5'd4);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_we", {31'd0, wb_we}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_wd", wb_wd, 32'd0);
        chk("rst_fwd", {30'd0, rs1_fwd, rs2_fwd}, 32'd0);
        chk("rst_count", 32'(count), 32'd0);

        // single push, written next cycle
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
        idle(1'b0);
        chk("t1_we", {31'd0, wb_we}, 32'd1);
        chk("t1_rd", {27'd0, wb_rd}, 32'd5);
        chk("t1_wd", wb_wd, 32'hDEADBEEF);
        chk("t1_count1", 32'(count), 32'd1);
        idle(1'b0);
        chk("t1_count0", 32'(count), 32'd0);

        // fill under stall, then push while popping at full
        for (int i = 1; i <= 4; i++)
            step(1'b0, 1'b1, 5'(i), 32'h100 + 32'(i), 1'b1, 5'd0, 5'd0);
        idle(1'b1);
        chk("t2_count4", 32'(count), 32'd4);
        chk("t2_full_ready", {31'd0, in_ready}, 32'd0);
        step(1'b0, 1'b1, 5'd9, 32'h999, 1'b0, 5'd0, 5'd0);
        chk("t2_ready_pop", {31'd0, in_ready}, 32'd1);
        chk("t2_rd1", {27'd0, wb_rd}, 32'd1);
        for (int i = 2; i <= 4; i++) begin
            idle(1'b0);
            if (i == 2) chk("t2_count_held", 32'(count), 32'd4);
            chk("t2_order", {27'd0, wb_rd}, 32'(i));
        end
        idle(1'b0);
        chk("t2_last", {27'd0, wb_rd}, 32'd9);
        idle(1'b0);

        // youngest duplicate wins
        step(1'b0, 1'b1, 5'd7, 32'h11, 1'b1, 5'd0, 5'd0);
        step(1'b0, 1'b1, 5'd7, 32'h22, 1'b1, 5'd0, 5'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0);
        chk("t3_fwd", {31'd0, rs1_fwd}, 32'd1);
        chk("t3_fwd_data", rs1_fwd_data, 32'h22);
        chk("t3_rs2_zero", {31'd0, rs2_fwd}, 32'd0);
        repeat (3) idle(1'b0);

        // rd = 0 handshakes but is not stored
        step(1'b0, 1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 5'd0);
        chk("t4_ready", {31'd0, in_ready}, 32'd1);
        idle(1'b0);
        chk("t4_count", 32'(count), 32'd0);
        chk("t4_we", {31'd0, wb_we}, 32'd0);

        // reset mid-operation with a push in the same cycle
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 5'd12, 32'hA0 + 32'(i), 1'b1, 5'd0, 5'd0);
        step(1'b1, 1'b1, 5'd12, 32'hBB, 1'b0, 5'd12, 5'd0);
        idle(1'b0);
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_we", {31'd0, wb_we}, 32'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd12, 5'd0);
        chk("t5_fwd", {31'd0, rs1_fwd}, 32'd0);

        // full-rate streaming across pointer wrap
        for (int i = 0; i < 2 * DEPTH + 1; i++)
            step(1'b0, 1'b1, 5'(1 + i % 31), 32'hC000 + 32'(i), 1'b0, 5'(1 + i % 31), 5'd0);
        repeat (2) idle(1'b0);

        // random traffic
        for (int n = 0; n < 400; n++)
            step(1'b0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        repeat (DEPTH + 2) idle(1'b0);
        chk("final_empty", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
